product_accumulator: RTL and testbench

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 100 ++++++++++
 tb/tb_product_accumulator.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums a run of multiplier products into a wide accumulator. A per-term
// timeout counts a missing product as zero. Overflow is sticky for the current run.
//
// state | meaning
// IDLE  | waiting for go
// REQ   | mul_start high, waiting for prod_ready or timeout
// GAP   | term consumed, waiting for prod_ready to drop
// DONE  | sum_out final, sum_valid high until sum_ack
module product_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [7:0]              count_len,
    input  logic [2*DATA_WIDTH-1:0] prod_in,
    input  logic                    prod_ready,
    output logic                    mul_start,
    output logic                    op_next,
    output logic [ACC_WIDTH-1:0]    sum_out,
    output logic                    sum_valid,
    input  logic                    sum_ack,
    output logic                    busy,
    output logic                    overflow
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = ACC_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t                state;
    logic [ACC_WIDTH-1:0]  acc;
    logic [7:0]            remaining;
    logic [TW-1:0]         timer;
    logic [SW-1:0]         sum_ext;

    // Top bit of sum_ext is the carry out of the accumulator.
    assign sum_ext   = {1'b0, acc} + SW'(prod_in);

    assign sum_out   = acc;
    assign busy      = (state != IDLE);
    assign mul_start = (state == REQ);
    assign sum_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= '0;
            timer     <= '0;
            op_next   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            op_next <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        acc       <= '0;
                        overflow  <= 1'b0;
                        timer     <= '0;
                        remaining <= count_len;
                        state     <= (count_len == 8'd0) ? DONE : REQ;
                    end
                end
                REQ: begin
                    if (prod_ready) begin
                        acc       <= sum_ext[ACC_WIDTH-1:0];
                        overflow  <= overflow | sum_ext[ACC_WIDTH];
                        op_next   <= 1'b1;
                        remaining <= remaining - 8'd1;
                        state     <= GAP;
                    end else if (timer == TW'(TIMEOUT-1)) begin
                        op_next   <= 1'b1;
                        remaining <= remaining - 8'd1;
                        state     <= GAP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                GAP: begin
                    // A product held high must drop before the next term can be taken.
                    if (!prod_ready) begin
                        if (remaining == 8'd0) begin
                            state <= DONE;
                        end else begin
                            timer <= '0;
                            state <= REQ;
                        end
                    end
                end
                DONE: begin
                    if (sum_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: a default-width instance for sequencing
// and timeout, plus a narrow instance for modulo wrap and overflow.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        go = 1'b0;
    logic [7:0]  count_len = '0;
    logic [63:0] prod_in = '0;
    logic        prod_ready = 1'b0;
    logic        sum_ack = 1'b0;
    logic        mul_start, op_next, sum_valid, busy, overflow;
    logic [71:0] sum_out;

    logic        go_b = 1'b0;
    logic [7:0]  count_len_b = '0;
    logic [7:0]  prod_in_b = '0;
    logic        prod_ready_b = 1'b0;
    logic        sum_ack_b = 1'b0;
    logic        mul_start_b, op_next_b, sum_valid_b, busy_b, overflow_b;
    logic [7:0]  sum_out_b;

    int errors = 0;
    int checks = 0;
    int op_cnt = 0;
    int ms_cnt = 0;
    int op_base;
    int ms_base;

    product_accumulator dut (
        .clk(clk), .reset(rst), .go(go), .count_len(count_len),
        .prod_in(prod_in), .prod_ready(prod_ready), .mul_start(mul_start),
        .op_next(op_next), .sum_out(sum_out), .sum_valid(sum_valid),
        .sum_ack(sum_ack), .busy(busy), .overflow(overflow)
    );

    product_accumulator #(.DATA_WIDTH(4), .ACC_WIDTH(8), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(rst), .go(go_b), .count_len(count_len_b),
        .prod_in(prod_in_b), .prod_ready(prod_ready_b), .mul_start(mul_start_b),
        .op_next(op_next_b), .sum_out(sum_out_b), .sum_valid(sum_valid_b),
        .sum_ack(sum_ack_b), .busy(busy_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (op_next) op_cnt++;
        if (mul_start) ms_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One term on the default instance: wait for mul_start, delay, present the
    // product, hold prod_ready for 'hold' cycles, then drop it.
    task automatic term(input logic [63:0] value, input int delay, input int hold, input bit noise);
        int n = 0;
        while (!mul_start && n < 40) begin
            step();
            n++;
        end
        chk("wait_mul_start", {127'd0, mul_start}, 128'd1);
        repeat (delay) step();
        prod_in    = value;
        prod_ready = 1'b1;
        step();
        chk("op_next_pulse", {127'd0, op_next}, 128'd1);
        chk("gap_mul_start", {127'd0, mul_start}, 128'd0);
        for (int i = 1; i < hold; i++) begin
            if (noise) begin
                go        = 1'b1;
                count_len = 8'd9;
                sum_ack   = 1'b1;
            end
            step();
            chk("gap_hold_ms", {127'd0, mul_start}, 128'd0);
            chk("gap_hold_op", {127'd0, op_next}, 128'd0);
        end
        go         = 1'b0;
        sum_ack    = 1'b0;
        prod_ready = 1'b0;
        step();
    endtask

    task automatic ack();
        sum_ack = 1'b1;
        step();
        sum_ack = 1'b0;
        chk("ack_valid_low", {127'd0, sum_valid}, 128'd0);
        chk("ack_idle", {127'd0, busy}, 128'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_sum", {56'd0, sum_out}, 128'd0);
        chk("rst_valid", {127'd0, sum_valid}, 128'd0);
        chk("rst_ms", {127'd0, mul_start}, 128'd0);
        chk("rst_op", {127'd0, op_next}, 128'd0);
        chk("rst_ovf", {127'd0, overflow}, 128'd0);

        // three terms 6, 10, 20; go on the very first edge after release
        rst = 1'b1;
        go = 1'b1;
        count_len = 8'd3;
        op_base = op_cnt;
        step();
        go = 1'b0;
        chk("go_busy", {127'd0, busy}, 128'd1);
        chk("go_ms", {127'd0, mul_start}, 128'd1);
        term(64'd6, 1, 1, 1'b0);
        term(64'd10, 1, 1, 1'b0);
        term(64'd20, 1, 1, 1'b0);
        chk("t3_valid", {127'd0, sum_valid}, 128'd1);
        chk("t3_sum", {56'd0, sum_out}, 128'd36);
        chk("t3_ovf", {127'd0, overflow}, 128'd0);
        chk("t3_ops", 128'(op_cnt - op_base), 128'd3);
        step();
        chk("t3_hold_valid", {127'd0, sum_valid}, 128'd1);
        chk("t3_hold_sum", {56'd0, sum_out}, 128'd36);
        ack();

        // first term times out, second is 5
        go = 1'b1;
        count_len = 8'd2;
        op_base = op_cnt;
        step();
        go = 1'b0;
        repeat (15) step();
        chk("pre_timeout_op", {127'd0, op_next}, 128'd0);
        chk("pre_timeout_ms", {127'd0, mul_start}, 128'd1);
        step();
        chk("timeout_op", {127'd0, op_next}, 128'd1);
        chk("timeout_sum", {56'd0, sum_out}, 128'd0);
        step();
        term(64'd5, 1, 1, 1'b0);
        chk("to_valid", {127'd0, sum_valid}, 128'd1);
        chk("to_sum", {56'd0, sum_out}, 128'd5);
        chk("to_ops", 128'(op_cnt - op_base), 128'd2);
        ack();

        // empty sum
        go = 1'b1;
        count_len = 8'd0;
        ms_base = ms_cnt;
        step();
        go = 1'b0;
        chk("empty_valid", {127'd0, sum_valid}, 128'd1);
        chk("empty_sum", {56'd0, sum_out}, 128'd0);
        step();
        chk("empty_no_ms", 128'(ms_cnt - ms_base), 128'd0);
        ack();

        // prod_ready held 5 cycles; go and sum_ack pulsed meanwhile must be ignored
        go = 1'b1;
        count_len = 8'd1;
        op_base = op_cnt;
        step();
        go = 1'b0;
        term(64'd9, 0, 5, 1'b1);
        chk("hold_valid", {127'd0, sum_valid}, 128'd1);
        chk("hold_sum", {56'd0, sum_out}, 128'd9);
        chk("hold_ops", 128'(op_cnt - op_base), 128'd1);
        ack();

        // narrow instance: 225 + 225 wraps to 194 with overflow
        go_b = 1'b1;
        count_len_b = 8'd2;
        step();
        go_b = 1'b0;
        prod_in_b = 8'd225;
        prod_ready_b = 1'b1;
        step();
        prod_ready_b = 1'b0;
        step();
        prod_ready_b = 1'b1;
        step();
        prod_ready_b = 1'b0;
        step();
        chk("wrap_valid", {127'd0, sum_valid_b}, 128'd1);
        chk("wrap_sum", {120'd0, sum_out_b}, 128'd194);
        chk("wrap_ovf", {127'd0, overflow_b}, 128'd1);
        sum_ack_b = 1'b1;
        step();
        sum_ack_b = 1'b0;
        chk("wrap_ovf_sticky", {127'd0, overflow_b}, 128'd1);
        go_b = 1'b1;
        count_len_b = 8'd1;
        step();
        go_b = 1'b0;
        chk("wrap_ovf_clear", {127'd0, overflow_b}, 128'd0);
        prod_in_b = 8'd3;
        prod_ready_b = 1'b1;
        step();
        prod_ready_b = 1'b0;
        step();
        chk("b2_sum", {120'd0, sum_out_b}, 128'd3);
        chk("b2_ovf", {127'd0, overflow_b}, 128'd0);
        sum_ack_b = 1'b1;
        step();
        sum_ack_b = 1'b0;

        // reset during term 2 of 4
        go = 1'b1;
        count_len = 8'd4;
        step();
        go = 1'b0;
        term(64'd1, 0, 1, 1'b0);
        chk("pre_rst_ms", {127'd0, mul_start}, 128'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_ms", {127'd0, mul_start}, 128'd0);
        chk("arst_sum", {56'd0, sum_out}, 128'd0);
        chk("arst_op", {127'd0, op_next}, 128'd0);
        chk("arst_valid", {127'd0, sum_valid}, 128'd0);
        step();
        rst = 1'b1;
        op_base = op_cnt;
        repeat (3) step();
        chk("post_rst_ops", 128'(op_cnt - op_base), 128'd0);
        chk("post_rst_valid", {127'd0, sum_valid}, 128'd0);
        go = 1'b1;
        count_len = 8'd1;
        step();
        go = 1'b0;
        term(64'd7, 0, 1, 1'b0);
        chk("post_rst_sum", {56'd0, sum_out}, 128'd7);
        chk("post_rst_done", {127'd0, sum_valid}, 128'd1);
        ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
